// File: rtl/alu_seq_ctrl.sv
// Multi-cycle command sequencer for alu_16bit: issues one op, optionally chains
// the result back as operand1 up to 2^RPTW times, and returns the final result.
module alu_seq_ctrl #(
   parameter int DWIDTH = 16,
   parameter int RPTW   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [DWIDTH-1:0] cmd_a,
   input  logic [DWIDTH-1:0] cmd_b,
   input  logic [RPTW-1:0]   cmd_rpt,
   input  logic              cmd_until_z,
   output logic [3:0]        alu_op,
   output logic [DWIDTH-1:0] alu_a,
   output logic [DWIDTH-1:0] alu_b,
   input  logic [DWIDTH-1:0] alu_out,
   input  logic              alu_z,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_data,
   output logic              rsp_nz,
   output logic [RPTW:0]     rsp_iters,
   output logic              rsp_err,
   output logic              busy
);

   localparam logic [3:0] OP_MAX = 4'b0110;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_OUT, WAIT_Z, DONE} state_t;

   state_t              state_q;
   logic                cmd_ready_q, rsp_valid_q, busy_q;
   logic [3:0]          alu_op_q;
   logic [DWIDTH-1:0]   alu_a_q, alu_b_q, rsp_data_q;
   logic                rsp_nz_q, rsp_err_q, until_z_q;
   logic [RPTW-1:0]     rpt_q;
   logic [RPTW:0]       iter_q;

   logic [RPTW:0]       iter_d;
   logic                finish_d;

   // Exit on the programmed count or, if requested, on the ALU's zero flag.
   assign iter_d   = iter_q + (RPTW+1)'(1);
   assign finish_d = (iter_d == ({1'b0, rpt_q} + (RPTW+1)'(1))) || (until_z_q && !alu_z);

   // NOTE: every register, including the captured command fields, is cleared by the
   // async reset so a command interrupted mid-flight leaves nothing behind; all
   // state updates use non-blocking assignments so each sees the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         rsp_data_q  <= '0;
         rsp_nz_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         until_z_q   <= 1'b0;
         rpt_q       <= '0;
         iter_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  rpt_q       <= cmd_rpt;
                  until_z_q   <= cmd_until_z;
                  iter_q      <= '0;
                  if (cmd_op > OP_MAX) begin
                     // Illegal opcode: answer immediately without touching the ALU.
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_nz_q    <= 1'b0;
                     rsp_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     rsp_err_q <= 1'b0;
                     alu_op_q  <= cmd_op;
                     alu_a_q   <= cmd_a;
                     alu_b_q   <= cmd_b;
                     state_q   <= ISSUE;
                  end
               end
            end
            ISSUE:    state_q <= WAIT_OUT;
            WAIT_OUT: state_q <= WAIT_Z;
            WAIT_Z: begin
               rsp_data_q <= alu_out;
               rsp_nz_q   <= alu_z;
               iter_q     <= iter_d;
               if (finish_d) begin
                  // Park the ALU on pass while idle.
                  alu_op_q    <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  alu_a_q <= alu_out;
                  state_q <= ISSUE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign busy      = busy_q;
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_nz    = rsp_nz_q;
   assign rsp_iters = iter_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural alu_16bit stand-in:
// directed scenarios, random commands, backpressure and mid-command reset.
module tb_alu_seq_ctrl;

   localparam int DW = 16;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_until_z;
   logic [3:0]    cmd_op, alu_op;
   logic [DW-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, rsp_data;
   logic [RW-1:0] cmd_rpt;
   logic          alu_z, rsp_valid, rsp_ready, rsp_nz, rsp_err, busy;
   logic [RW:0]   rsp_iters;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.DWIDTH(DW), .RPTW(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_rpt(cmd_rpt), .cmd_until_z(cmd_until_z),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_z(alu_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_nz(rsp_nz), .rsp_iters(rsp_iters), .rsp_err(rsp_err), .busy(busy)
   );

   // Opcode meanings: pass, add, sub, shl1, inc (4/5 unused here).
   function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a << 1;
         4'd6:    return a + 16'd1;
         default: return a;
      endcase
   endfunction

   // ALU stand-in: registered result, zero flag one clock behind the result.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out <= '0;
         alu_z   <= 1'b0;
      end else begin
         alu_out <= alu_fn(alu_op, alu_a, alu_b);
         alu_z   <= (alu_out != '0);
      end
   end

   typedef struct {
      logic [DW-1:0] data;
      logic          nz;
      logic [RW:0]   iters;
      logic          err;
      int            k;
      int            hold;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   last_hs = -100;
   int   n_chk = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Reference: run the chain with plain arithmetic from the command fields.
   function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [RW-1:0] rpt,
                                  input logic uz);
      exp_t          e;
      logic [DW-1:0] x;
      e.k = 0;
      e.hold = 0;
      e.err = (op > 4'd6);
      e.iters = '0;
      x = '0;
      if (!e.err) begin
         x = a;
         for (int i = 0; i <= int'(rpt); i++) begin
            x = alu_fn(op, x, b);
            e.iters++;
            if (uz && x == '0) break;
         end
      end
      e.data = x;
      e.nz = (x != '0);
      return e;
   endfunction

   task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [RW-1:0] rpt, input logic uz, input int hold);
      exp_t e;
      bit   was_busy;
      bit   got;
      int   waited;
      e = model(op, a, b, rpt, uz);
      e.hold = hold;
      @(negedge clk);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_rpt = rpt; cmd_until_z = uz;
      cmd_valid = 1'b1;
      was_busy = busy;
      got = 1'b0;
      waited = 0;
      while (!got && waited < 400) begin
         got = cmd_ready;
         @(posedge clk);
         if (!got) begin
            @(negedge clk);
            waited++;
         end
      end
      #1;
      cmd_valid = 1'b0;
      if (!got) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         e.k = cyc;
         exp_q.push_back(e);
         if (was_busy) check("accept_after_rsp_hs", e.k, last_hs + 1);
      end
   endtask

   // Operand stability and feedback chain over cycles k+1 .. k+3N.
   task automatic watch_alu(input logic [3:0] op, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input int iters);
      logic [DW-1:0] x;
      x = a;
      for (int i = 0; i < iters; i++) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("alu_op_held", alu_op, op);
            check("alu_a_iter", alu_a, x);
            check("alu_b_held", alu_b, b);
         end
         x = alu_fn(op, x, b);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("idle_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever a response appears.
   initial begin : monitor
      exp_t e;
      int   hold;
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid) begin
            hold = 0;
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_nz", rsp_nz, e.nz);
               check("rsp_iters", rsp_iters, e.iters);
               check("rsp_err", rsp_err, e.err);
               check("rsp_latency", cyc, e.k + 3 * int'(e.iters));
               if (e.err) check("illegal_alu_op", alu_op, 4'd0);
               hold = e.hold;
               for (int h = 0; h < hold; h++) begin
                  @(negedge clk);
                  check("bp_valid", rsp_valid, 1'b1);
                  check("bp_data", rsp_data, e.data);
                  check("bp_nz_iters", {rsp_nz, rsp_iters}, {e.nz, e.iters});
                  check("bp_cmd_ready", cmd_ready, 1'b0);
                  check("bp_busy", busy, 1'b1);
               end
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            last_hs = cyc;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [3:0]    legal_ops [5];
      logic [3:0]    op;
      logic [DW-1:0] a, b;
      logic [RW-1:0] rpt;
      legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_rpt = '0; cmd_until_z = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_cmd_ready", cmd_ready, 1'b0);
      check("reset_busy_valid", {busy, rsp_valid}, 2'b00);
      check("reset_alu", {alu_op, alu_a, alu_b}, '0);
      rst_n = 1'b1;

      send(4'd1, 16'h1234, 16'h0101, 4'd0, 1'b0, 0);
      watch_alu(4'd1, 16'h1234, 16'h0101, 1);
      wait_idle();
      send(4'd3, 16'h0001, 16'h0000, 4'd3, 1'b0, 1);
      watch_alu(4'd3, 16'h0001, 16'h0000, 4);
      wait_idle();
      send(4'd2, 16'h0005, 16'h0001, 4'd15, 1'b1, 0);
      send(4'd2, 16'h0005, 16'h0001, 4'd15, 1'b0, 0);
      send(4'd6, 16'hFFFF, 16'h0000, 4'd0, 1'b0, 0);
      send(4'd9, 16'h1111, 16'h2222, 4'd2, 1'b0, 0);
      wait_idle();

      send(4'd1, 16'h0F00, 16'h00F0, 4'd0, 1'b0, 6);
      send(4'd2, 16'h0100, 16'h0001, 4'd1, 1'b0, 0);
      wait_idle();

      // Reset during WAIT_OUT of iteration 2 of a 4-iteration chain.
      send(4'd3, 16'h0001, 16'h0000, 4'd3, 1'b0, 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ctrl", {cmd_ready, busy, rsp_valid, rsp_err, rsp_nz}, 5'b0);
      check("rst_mid_alu", {alu_op, alu_a, alu_b}, '0);
      check("rst_mid_rsp", {rsp_data, rsp_iters}, '0);
      void'(exp_q.pop_back());
      repeat (2) @(negedge clk);
      check("rst_hold_valid", rsp_valid, 1'b0);
      rst_n = 1'b1;
      send(4'd1, 16'h1234, 16'h0101, 4'd0, 1'b0, 0);
      wait_idle();

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(7, 15));
         else op = legal_ops[$urandom_range(0, 4)];
         a = $urandom_range(0, 1) ? 16'($urandom_range(0, 8)) : 16'($urandom);
         b = $urandom_range(0, 1) ? 16'($urandom_range(1, 3)) : 16'($urandom);
         rpt = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         send(op, a, b, rpt, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer sitting between the instruction/control path and alu_16bit.
- Accepts one ALU command at a time over a valid/ready handshake and drives the ALU's operation and operand inputs.
- Supports 1..16 chained iterations: each iteration after the first feeds the previous ALU result back as operand1. Optional early exit when the result becomes zero.
- Returns the final result, the non-zero flag and the executed iteration count over a valid/ready response interface.

Parameters:
DWIDTH  16  datapath width; must match the ALU instance.
RPTW  4  width of repeat field; iterations = cmd_rpt+1 (1..2^RPTW).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  high only in IDLE.
cmd_op  in  4  ALU opcode; valid codes 0000..0110.
cmd_a  in  DWIDTH  initial operand1.
cmd_b  in  DWIDTH  operand2, held for all iterations.
cmd_rpt  in  RPTW  extra iterations.
cmd_until_z  in  1  stop early when result is zero.
alu_op  out  4  to ALU operation.
alu_a  out  DWIDTH  to ALU operand1.
alu_b  out  DWIDTH  to ALU operand2.
alu_out  in  DWIDTH  ALU registered result.
alu_z  in  1  ALU flag; 1 = result non-zero, 0 = result zero; lags alu_out by one clock.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_data  out  DWIDTH  final result.
rsp_nz  out  1  alu_z captured from the final iteration.
rsp_iters  out  RPTW+1  iterations executed.
rsp_err  out  1  illegal opcode.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All registered outputs are 0; alu_op=0000 (pass). cmd_ready goes high once reset is released. Reset takes effect in any state; an in-flight command is discarded with no response.
- States: IDLE, ISSUE, WAIT_OUT, WAIT_Z, DONE.
- IDLE:
  - Accept when cmd_valid & cmd_ready at edge k. Latch op, b, rpt, until_z. Clear the iteration counter.
  - If cmd_op > 0110: go to DONE with rsp_err=1, rsp_data=0, rsp_nz=0, rsp_iters=0, so rsp_valid is high in cycle k+1. The ALU is not driven; alu_op stays 0000.
  - Otherwise: alu_op<=cmd_op, alu_a<=cmd_a, alu_b<=cmd_b, go to ISSUE.
- ISSUE: the ALU samples its inputs at the end of this cycle. Go to WAIT_OUT.
- WAIT_OUT: alu_out is valid; alu_z is updated at the end of this cycle. Go to WAIT_Z.
- WAIT_Z:
  - Capture rsp_data<=alu_out and rsp_nz<=alu_z; increment the iteration counter.
  - If done: go to DONE. Done means iterations==rpt+1, or (until_z & alu_z==0).
  - Else: alu_a<=alu_out, go to ISSUE.
- alu_op, alu_a and alu_b are held stable from ISSUE through WAIT_Z of each iteration.
- DONE: rsp_valid=1. Response fields hold stable until rsp_valid & rsp_ready, then go to IDLE. No command is accepted in the same cycle as the response handshake.
- Latency:
  - Accept at edge of cycle k; rsp_valid first high in cycle k+3N+1 for N iterations.
  - Single operation: k+4.
- Arithmetic is performed by the ALU only. Wrap-around results pass through unmodified. rsp_iters counts 1..2^RPTW without overflow.
- cmd_rpt is ignored when an until_z exit occurs first. The early-exit check uses alu_z only, never a local compare.

Test Plan:
1. ADD: op=0001, a=0x1234, b=0x0101, rpt=0 → rsp_data=0x1335, nz=1, iters=1, err=0; rsp_valid in cycle k+4; alu_op/a/b stable for cycles k+1..k+3.
2. Chained SHL1: op=0011, a=0x0001, rpt=3 → rsp_data=0x0010, iters=4, rsp_valid at k+13; alu_a observed as 0x0001, 0x0002, 0x0004, 0x0008.
3. Early exit: op=0010, a=0x0005, b=0x0001, rpt=15, until_z=1 → rsp_data=0x0000, nz=0, iters=5, rsp_valid at k+16. Same stimulus with until_z=0 → iters=16, rsp_data=0xFFF5, nz=1.
4. Wrap and illegal opcode:
   - op=0110, a=0xFFFF → rsp_data=0x0000, nz=0.
   - op=1001 → err=1, data=0, iters=0, rsp_valid at k+1, alu_op stays 0000.
5. Backpressure: hold rsp_ready=0 for 6 cycles after rsp_valid → rsp fields stable, cmd_ready=0, busy=1; a second cmd_valid is not accepted until the cycle after the rsp handshake.
6. Reset mid-op: assert rst_n=0 during WAIT_OUT of iteration 2 of a 4-iteration command → all outputs 0 immediately (asynchronously), no rsp_valid; after release, a new ADD completes normally at k+4.
